// File: rtl/inst_encoder.sv
// RV32 instruction-word builder: validates and encodes one request per cycle into
// a 2-entry output FIFO; illegal requests are dropped and reported via err_* outputs.
module inst_encoder #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_op,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 err_pulse,
  output logic [2:0]           err_code,
  output logic [CNT_WIDTH-1:0] emit_count,
  output logic [CNT_WIDTH-1:0] err_count
);
  logic [31:0]          mem_q [2];
  logic [31:0]          mem_d [2];
  logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 alive_q, alive_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [2:0]           err_code_q, err_code_d;
  logic [CNT_WIDTH-1:0] emit_q, emit_d, errc_q, errc_d;

  logic signed [31:0] simm;
  logic [2:0]         chk_code;
  logic [31:0]        word;
  logic               accept, push, pop;

  // alive_q keeps in_ready low during reset and rises on the first edge after release
  assign in_ready   = alive_q & (count_q != 2'd2);
  assign out_valid  = (count_q != 2'd0);
  assign out_instr  = out_valid ? mem_q[rd_ptr_q] : 32'd0;
  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;
  assign emit_count = emit_q;
  assign err_count  = errc_q;

  always_comb begin
    simm     = $signed(in_imm);
    chk_code = 3'd0;
    case (in_fmt)
      3'd0: chk_code = 3'd0;
      3'd1, 3'd2:
        if (simm < -32'sd2048 || simm > 32'sd2047) chk_code = 3'd2;
      3'd3:
        if (simm < -32'sd4096 || simm > 32'sd4094) chk_code = 3'd2;
        else if (in_imm[0])                        chk_code = 3'd3;
      3'd4:
        if (in_imm[11:0] != 12'd0) chk_code = 3'd4;
      3'd5:
        if (simm < -32'sd1048576 || simm > 32'sd1048574) chk_code = 3'd2;
        else if (in_imm[0])                              chk_code = 3'd3;
      default: chk_code = 3'd1;
    endcase
  end

  always_comb begin
    word = 32'd0;
    case (in_fmt)
      3'd0: word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
      3'd1: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
      3'd2: word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
      3'd3: word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_op};
      3'd4: word = {in_imm[31:12], in_rd, in_op};
      3'd5: word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
      default: word = 32'd0;
    endcase
  end

  always_comb begin
    accept      = in_valid & in_ready;
    push        = accept & (chk_code == 3'd0);
    pop         = out_valid & out_ready;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    alive_d     = 1'b1;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    emit_d      = emit_q;
    errc_d      = errc_q;
    if (push) begin
      mem_d[wr_ptr_q] = word;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
    if (accept && chk_code != 3'd0) begin
      err_pulse_d = 1'b1;
      err_code_d  = chk_code;
      if (errc_q != '1) errc_d = errc_q + 1'b1;
    end
    if (pop && emit_q != '1) emit_d = emit_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0]    <= 32'd0;
      mem_q[1]    <= 32'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      alive_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 3'd0;
      emit_q      <= '0;
      errc_q      <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alive_q     <= alive_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      emit_q      <= emit_d;
      errc_q      <= errc_d;
    end
  end
endmodule
